// File: rtl/regfile_pkg.sv
// Shared types and sizing constants for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int XLEN_DEF    = 32;
    localparam int NREGS_RV32I = 32;
    localparam int NREGS_RV32E = 16;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue marks a destination pending, writeback retires it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_RV32I,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             ready_i,
    input  logic             issue_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic             wb_i,
    input  logic [AW-1:0]    wb_addr_i,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // The set is applied after the clear so a same-cycle issue keeps the
    // register pending for its new producer.
    always_comb begin
        busy_d = busy_q;
        if (ready_i) begin
            if (wb_i) begin
                busy_d[wb_addr_i] = 1'b0;
            end
            if (issue_i) begin
                busy_d[issue_rd_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD combinational read lanes, write bypass,
// busy scoreboard and a post-reset zero sweep of the storage array.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_RV32I,
    parameter int  NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]    rd_busy_o,
    input  logic [AW-1:0]     w_addr_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic              issue_i,
    input  logic [AW-1:0]     issue_rd_i,
    output logic              ready_o
);

    localparam logic [AW:0]   NREGS_LIM = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_LIM);
    endfunction

    state_e          state_q;
    state_e          state_d;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_d;
    logic            sweep_we;
    logic            ready;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_we = 1'b0;
        case (state_q)
            INIT: begin
                sweep_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign ready   = (state_q == RUN);
    // ready_o is a level, not a handshake: while low, we_i and issue_i are
    // silently dropped; while high both are accepted every cycle without stall.
    assign ready_o = ready;

    logic wb_ok;
    logic iss_ok;
    assign wb_ok  = ready && we_i && (w_addr_i != '0) && in_range(w_addr_i);
    assign iss_ok = issue_i && (issue_rd_i != '0) && in_range(issue_rd_i);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    always_comb begin
        wr_en   = wb_ok;
        wr_addr = w_addr_i;
        wr_data = wdata_i;
        if (sweep_we) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = '0;
        end
    end

    // No reset on the array so it can map onto LUT-RAM; the sweep clears it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .ready_i    (ready),
        .issue_i    (iss_ok),
        .issue_rd_i (issue_rd_i),
        .wb_i       (wb_ok),
        .wb_addr_i  (w_addr_i),
        .busy_o     (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_lane
        logic [AW-1:0] addr;
        logic          valid;
        logic          hit;

        assign addr  = rd_addr_i[k*AW +: AW];
        assign valid = ready && (addr != '0) && in_range(addr);
        assign hit   = we_i && (w_addr_i == addr);

        assign rd_data_o[k*XLEN +: XLEN] = !valid ? '0 : (hit ? wdata_i : mem[addr]);
        assign rd_busy_o[k]              = valid && busy[addr] && !hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32-reg/2-lane and a 16-reg/3-lane instance run side
// by side against an array-based behavioural model plus directed literal checks.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Unified stimulus: index 0 drives the 32x2 instance, index 1 the 16x3 one.
  logic [4:0]  raddr    [2][3];
  logic [4:0]  w_addr   [2];
  logic        we       [2];
  logic [31:0] wdata    [2];
  logic        issue    [2];
  logic [4:0]  issue_rd [2];

  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_ready;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_ready;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut_a (
    .clk_i      (clk),
    .reset_n    (rst_n),
    .rd_addr_i  ({raddr[0][1], raddr[0][0]}),
    .rd_data_o  (a_rd_data),
    .rd_busy_o  (a_rd_busy),
    .w_addr_i   (w_addr[0]),
    .we_i       (we[0]),
    .wdata_i    (wdata[0]),
    .issue_i    (issue[0]),
    .issue_rd_i (issue_rd[0]),
    .ready_o    (a_ready)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3)) dut_b (
    .clk_i      (clk),
    .reset_n    (rst_n),
    .rd_addr_i  ({raddr[1][2][3:0], raddr[1][1][3:0], raddr[1][0][3:0]}),
    .rd_data_o  (b_rd_data),
    .rd_busy_o  (b_rd_busy),
    .w_addr_i   (w_addr[1][3:0]),
    .we_i       (we[1]),
    .wdata_i    (wdata[1]),
    .issue_i    (issue[1]),
    .issue_rd_i (issue_rd[1][3:0]),
    .ready_o    (b_ready)
  );

  function automatic int nregs_of(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int nrd_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg   [2][32];
  bit          m_busy  [2][32];
  bit          m_ready [2];
  int          m_cnt   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ready[i] <= 1'b0;
        m_cnt[i]   <= 0;
        for (int r = 0; r < 32; r++) m_busy[i][r] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_ready[i]) begin
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == nregs_of(i) - 1) begin
            m_ready[i] <= 1'b1;
            for (int r = 0; r < 32; r++) m_reg[i][r] <= 32'h0;
          end
        end else begin
          if (we[i] && w_addr[i] != 0) begin
            m_reg[i][w_addr[i]]  <= wdata[i];
            m_busy[i][w_addr[i]] <= 1'b0;
          end
          if (issue[i] && issue_rd[i] != 0) m_busy[i][issue_rd[i]] <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_data(input int i, input int k);
    int a = int'(raddr[i][k]);
    if (!m_ready[i] || a == 0 || a >= nregs_of(i)) return 32'h0;
    if (we[i] && int'(w_addr[i]) == a) return wdata[i];
    return m_reg[i][a];
  endfunction

  function automatic logic exp_busy(input int i, input int k);
    int a = int'(raddr[i][k]);
    if (!m_ready[i] || a == 0 || a >= nregs_of(i)) return 1'b0;
    if (we[i] && int'(w_addr[i]) == a) return 1'b0;
    return m_busy[i][a];
  endfunction

  function automatic logic [31:0] act_data(input int i, input int k);
    return (i == 0) ? a_rd_data[k*32 +: 32] : b_rd_data[k*32 +: 32];
  endfunction

  function automatic logic act_busy(input int i, input int k);
    return (i == 0) ? a_rd_busy[k] : b_rd_busy[k];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d_ready", i), {31'b0, (i == 0) ? a_ready : b_ready},
              {31'b0, m_ready[i]});
        for (int k = 0; k < nrd_of(i); k++) begin
          check($sformatf("u%0d_data%0d", i, k), act_data(i, k), exp_data(i, k));
          check($sformatf("u%0d_busy%0d", i, k), {31'b0, act_busy(i, k)},
                {31'b0, exp_busy(i, k)});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      w_addr[i] = '0; we[i] = 1'b0; wdata[i] = '0;
      issue[i] = 1'b0; issue_rd[i] = '0;
      for (int k = 0; k < 3; k++) raddr[i][k] = '0;
    end
  endtask

  function automatic logic [4:0] rand_addr(input int i);
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, nregs_of(i) - 1));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic count_sweep(input string tag);
    int first_a = 0;
    int first_b = 0;
    for (int n = 1; n <= 60 && (first_a == 0 || first_b == 0); n++) begin
      step();
      if (a_ready && first_a == 0) begin
        first_a = n;
        we[0] = 1'b0;
      end
      if (b_ready && first_b == 0) first_b = n;
    end
    check({tag, "_sweep_a"}, first_a, 31);
    check({tag, "_sweep_b"}, first_b, 15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    raddr[0][0] = 5'd1; raddr[0][1] = 5'd2;
    repeat (3) step();
    check("rst_ready_a", {31'b0, a_ready}, 0);
    check("rst_data_a0", a_rd_data[31:0], 0);
    check("rst_busy_a", {30'b0, a_rd_busy}, 0);

    // Release; a write to x5 during the sweep must be dropped.
    rst_n = 1'b1;
    we[0] = 1'b1; w_addr[0] = 5'd5; wdata[0] = 32'hFFFF_FFFF; raddr[0][0] = 5'd5;
    count_sweep("init");
    @(negedge clk);
    check("init_x5_zero", a_rd_data[31:0], 0);

    // Write/read on both instances.
    step();
    we[0] = 1'b1; w_addr[0] = 5'd1; wdata[0] = 32'hDEAD_BEEF;
    we[1] = 1'b1; w_addr[1] = 5'd3; wdata[1] = 32'h0000_0111;
    step();
    w_addr[0] = 5'd2; wdata[0] = 32'hCAFE_BABE;
    w_addr[1] = 5'd9; wdata[1] = 32'h0000_0222;
    step();
    we[0] = 1'b0; raddr[0][0] = 5'd1; raddr[0][1] = 5'd2;
    w_addr[1] = 5'd15; wdata[1] = 32'h0000_0333;
    @(negedge clk);
    check("rd_x1", a_rd_data[31:0], 32'hDEAD_BEEF);
    check("rd_x2", a_rd_data[63:32], 32'hCAFE_BABE);
    step();
    we[1] = 1'b0; raddr[1][0] = 5'd3; raddr[1][1] = 5'd9; raddr[1][2] = 5'd15;
    we[0] = 1'b1; w_addr[0] = 5'd0; wdata[0] = 32'h1234_5678; raddr[0][0] = 5'd0;
    @(negedge clk);
    check("x0_bypass_zero", a_rd_data[31:0], 0);
    check("b_lane0_x3", b_rd_data[31:0], 32'h111);
    check("b_lane1_x9", b_rd_data[63:32], 32'h222);
    check("b_lane2_x15", b_rd_data[95:64], 32'h333);
    step();
    we[0] = 1'b0;
    for (int k = 0; k < 3; k++) raddr[1][k] = 5'd0;
    @(negedge clk);
    check("x0_stored_zero", a_rd_data[31:0], 0);
    check("b_x0_lanes", b_rd_data, 96'h0);

    // Bypass onto a busy register.
    step();
    issue[0] = 1'b1; issue_rd[0] = 5'd7;
    step();
    issue[0] = 1'b0; raddr[0][0] = 5'd7;
    @(negedge clk);
    check("x7_busy", {31'b0, a_rd_busy[0]}, 1);
    step();
    we[0] = 1'b1; w_addr[0] = 5'd7; wdata[0] = 32'hA5A5_A5A5;
    @(negedge clk);
    check("bypass_data", a_rd_data[31:0], 32'hA5A5_A5A5);
    check("bypass_not_busy", {31'b0, a_rd_busy[0]}, 0);
    step();
    we[0] = 1'b0;
    @(negedge clk);
    check("x7_stored", a_rd_data[31:0], 32'hA5A5_A5A5);

    // Scoreboard timing on x3 via lane 1.
    step();
    issue[0] = 1'b1; issue_rd[0] = 5'd3; raddr[0][1] = 5'd3;
    @(negedge clk);
    check("sb_t0", {31'b0, a_rd_busy[1]}, 0);
    step();
    issue[0] = 1'b0;
    @(negedge clk);
    check("sb_t1", {31'b0, a_rd_busy[1]}, 1);
    step();
    @(negedge clk);
    check("sb_t2", {31'b0, a_rd_busy[1]}, 1);
    step();
    we[0] = 1'b1; w_addr[0] = 5'd3; wdata[0] = 32'h5;
    step();
    we[0] = 1'b0;
    @(negedge clk);
    check("sb_t4", {31'b0, a_rd_busy[1]}, 0);
    step();
    issue[0] = 1'b1; issue_rd[0] = 5'd3; we[0] = 1'b1; w_addr[0] = 5'd3; wdata[0] = 32'h6;
    step();
    issue[0] = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    check("sb_set_wins", {31'b0, a_rd_busy[1]}, 1);

    // Reset in RUN, then again mid-sweep at index 10.
    step();
    issue[0] = 1'b1; issue_rd[0] = 5'd4;
    step();
    issue[0] = 1'b0; raddr[0][1] = 5'd4;
    @(negedge clk);
    check("x4_busy", {31'b0, a_rd_busy[1]}, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, a_ready}, 0);
    check("mid_rst_busy4", {31'b0, a_rd_busy[1]}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (9) step();
    check("sweep_idx10_ready", {31'b0, a_ready}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("sweep_rst_ready", {31'b0, a_ready}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    count_sweep("rerun");

    // Randomised traffic, checked every cycle by the compare process.
    repeat (400) begin
      step();
      for (int i = 0; i < 2; i++) begin
        we[i]       = 1'($urandom_range(0, 1));
        w_addr[i]   = rand_addr(i);
        wdata[i]    = $urandom;
        issue[i]    = 1'($urandom_range(0, 1));
        issue_rd[i] = rand_addr(i);
        for (int k = 0; k < 3; k++) raddr[i][k] = rand_addr(i);
      end
    end
    step();
    idle();
    @(negedge clk);
    #1 cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
